// File: rtl/uc_dispatch_arbiter_pkg.sv
// uc_pkg: holds the shared default sizing and literal/count types for the
// unit-clause dispatch arbiter slice.
//   UC_LENGTH_DEF  literal id space
//   NUM_ENG_DEF    number of propagation engines
//   UCA_DEPTH_DEF  arbiter FIFO depth (power of two, >= 2)
//   LIT_W / CNT_W  literal and occupancy widths at the defaults
package uc_pkg;

    localparam int UC_LENGTH_DEF = 1024;
    localparam int NUM_ENG_DEF   = 4;
    localparam int UCA_DEPTH_DEF = 8;

    localparam int LIT_W = $clog2(UC_LENGTH_DEF);
    localparam int CNT_W = $clog2(UCA_DEPTH_DEF + 1);

    typedef logic [LIT_W-1:0] lit_t;
    typedef logic [CNT_W-1:0] uca_cnt_t;

endpackage

// File: rtl/uc_dispatch_arbiter_if.sv
// uc_dispatch_arbiter_if: bundles the producer handshakes (memory loader and
// engines), the flush strobe, the UCQ consumer handshake and the occupancy
// status of the dispatch arbiter.
//   master: drives mem_valid/mem_lit, eng_valid/eng_lit, flush, ucq_ready
//   slave : drives mem_ready, eng_ready, ucq_valid/ucq_lit, count/full/empty
interface uc_dispatch_arbiter_if #(
    parameter int LIT_W   = uc_pkg::LIT_W,
    parameter int NUM_ENG = uc_pkg::NUM_ENG_DEF,
    parameter int CNT_W   = uc_pkg::CNT_W
);
    logic                     mem_valid;
    logic [LIT_W-1:0]         mem_lit;
    logic                     mem_ready;
    logic [NUM_ENG-1:0]       eng_valid;
    logic [NUM_ENG*LIT_W-1:0] eng_lit;
    logic [NUM_ENG-1:0]       eng_ready;
    logic                     flush;
    logic                     ucq_valid;
    logic [LIT_W-1:0]         ucq_lit;
    logic                     ucq_ready;
    logic [CNT_W-1:0]         count;
    logic                     full;
    logic                     empty;

    modport master (
        output mem_valid, mem_lit, eng_valid, eng_lit, flush, ucq_ready,
        input  mem_ready, eng_ready, ucq_valid, ucq_lit, count, full, empty
    );

    modport slave (
        input  mem_valid, mem_lit, eng_valid, eng_lit, flush, ucq_ready,
        output mem_ready, eng_ready, ucq_valid, ucq_lit, count, full, empty
    );
endinterface

// File: rtl/uc_dispatch_arbiter_fifo.sv
// uc_fifo: synchronous FIFO with push/pop/flush and occupancy status.
//   clk, rst   clock and asynchronous active-high reset
//   push       write push_data at the tail (ignored when full or flushing)
//   pop        advance the head (ignored when empty or flushing)
//   flush      discard all contents on the next edge
//   rd_data    current head, read straight from storage (0 when empty)
//   count/full/empty  occupancy
module uc_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] storage_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // A full FIFO refuses the push even if a pop happens in the same cycle.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) tail_d = tail_q + PTR_W'(1);
            if (do_pop)  head_d = head_q + PTR_W'(1);
            if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; stale words are never exposed because the
    // head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) storage_q[tail_q] <= push_data;
    end

    assign rd_data = empty ? '0 : storage_q[head_q];
    assign count   = count_q;

endmodule

// File: rtl/uc_dispatch_arbiter.sv
// uc_dispatch_arbiter: funnels unit literals from the clause-memory loader and
// NUM_ENG propagation engines into one buffered unit-clause queue.
//   clk, rst  clock and asynchronous active-high reset
//   bus       slave side of uc_dispatch_arbiter_if:
//             mem_valid/mem_lit/mem_ready   loader handshake (strict priority)
//             eng_valid/eng_lit/eng_ready   engine handshakes (round-robin)
//             flush                          drop everything queued
//             ucq_valid/ucq_lit/ucq_ready    consumer side (FIFO head)
//             count/full/empty               FIFO occupancy
// NUM_ENG must be >= 1; UCA_DEPTH must be a power of two >= 2.
module uc_dispatch_arbiter
    import uc_pkg::*;
#(
    parameter int UC_LENGTH = UC_LENGTH_DEF,
    parameter int NUM_ENG   = NUM_ENG_DEF,
    parameter int UCA_DEPTH = UCA_DEPTH_DEF
) (
    input logic                clk,
    input logic                rst,
    uc_dispatch_arbiter_if.slave bus
);

    localparam int L_W  = $clog2(UC_LENGTH);
    localparam int RR_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

    logic [L_W-1:0]  eng_lit_arr [NUM_ENG];
    logic [RR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [RR_W-1:0] eng_sel;
    logic            eng_hit;
    logic            grant_ok;
    logic            mem_grant;
    logic            eng_grant;
    logic            fifo_push;
    logic [L_W-1:0]  fifo_push_data;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ENG; gi++) begin : g_unpack
            assign eng_lit_arr[gi] = bus.eng_lit[gi*L_W +: L_W];
        end
    endgenerate

    // Round-robin search: first requesting engine at or after rr_ptr,
    // wrapping modulo NUM_ENG.
    always_comb begin
        logic [RR_W-1:0] idx;
        eng_hit = 1'b0;
        eng_sel = '0;
        idx     = '0;
        for (int k = 0; k < NUM_ENG; k++) begin
            idx = RR_W'((int'(rr_ptr_q) + k) % NUM_ENG);
            if (!eng_hit && bus.eng_valid[idx]) begin
                eng_hit = 1'b1;
                eng_sel = idx;
            end
        end
    end

    // No grant while resetting, full, or flushing, so no handshake can
    // complete in those cycles.
    assign grant_ok  = !rst && !fifo_full && !bus.flush;
    assign mem_grant = grant_ok && bus.mem_valid;
    assign eng_grant = grant_ok && !bus.mem_valid && eng_hit;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (eng_grant) rr_ptr_d = RR_W'((int'(eng_sel) + 1) % NUM_ENG);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_ptr_q <= '0;
        else     rr_ptr_q <= rr_ptr_d;
    end

    assign fifo_push      = mem_grant || eng_grant;
    assign fifo_push_data = bus.mem_valid ? bus.mem_lit : eng_lit_arr[eng_sel];
    assign fifo_pop       = bus.ucq_ready && !rst;

    uc_fifo #(
        .DEPTH (UCA_DEPTH),
        .WIDTH (L_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .flush     (bus.flush),
        .rd_data   (bus.ucq_lit),
        .count     (bus.count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.mem_ready = mem_grant;
    assign bus.eng_ready = eng_grant ? (NUM_ENG'(1) << eng_sel) : '0;
    assign bus.ucq_valid = !fifo_empty;
    assign bus.full      = fifo_full;
    assign bus.empty     = fifo_empty;

endmodule

// File: tb/tb_uc_dispatch_arbiter.sv
// Directed bench for uc_dispatch_arbiter with a pop scoreboard.
module tb_uc_dispatch_arbiter;
    import uc_pkg::*;

    logic clk;
    logic rst;

    uc_dispatch_arbiter_if #(.LIT_W(10), .NUM_ENG(4), .CNT_W(4)) bus ();

    uc_dispatch_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int sb[$];
    int max_cnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_eng(input logic [3:0] v, input int l0, input int l1,
                           input int l2, input int l3);
        bus.eng_valid = v;
        bus.eng_lit   = {10'(l3), 10'(l2), 10'(l1), 10'(l0)};
    endtask

    // Monitor: every completed pop is compared against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.ucq_valid && bus.ucq_ready && !bus.flush) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_unexpected: got lit %0d expected none", bus.ucq_lit);
                end else begin
                    int e;
                    e = sb.pop_front();
                    $display("pop lit=%0d expected=%0d", bus.ucq_lit, e);
                    chk("pop_lit", int'(bus.ucq_lit), e);
                end
            end
        end
    end

    initial begin
        rst           = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_lit   = '0;
        bus.flush     = 1'b0;
        bus.ucq_ready = 1'b0;
        set_eng(4'b0000, 0, 0, 0, 0);

        // Asynchronous reset mid-cycle, with a request present.
        #3 rst = 1'b1;
        bus.mem_valid = 1'b1;
        #1;
        chk("rst_empty", int'(bus.empty), 1);
        chk("rst_count", int'(bus.count), 0);
        chk("rst_ucq_valid", int'(bus.ucq_valid), 0);
        chk("rst_ucq_lit", int'(bus.ucq_lit), 0);
        chk("rst_full", int'(bus.full), 0);
        chk("rst_mem_ready", int'(bus.mem_ready), 0);
        chk("rst_eng_ready", int'(bus.eng_ready), 0);
        bus.mem_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Memory has strict priority over engines.
        bus.mem_valid = 1'b1; bus.mem_lit = 10'd5;
        set_eng(4'b1111, 10, 11, 12, 13);
        @(negedge clk);
        chk("prio_mem_ready", int'(bus.mem_ready), 1);
        chk("prio_eng_ready", int'(bus.eng_ready), 0);
        $display("push mem lit=5");
        sb.push_back(5);
        tick();
        bus.mem_valid = 1'b0;
        set_eng(4'b0000, 0, 0, 0, 0);
        @(negedge clk);
        chk("prio_ucq_valid", int'(bus.ucq_valid), 1);
        chk("prio_ucq_lit", int'(bus.ucq_lit), 5);
        chk("prio_count", int'(bus.count), 1);
        tick();
        bus.ucq_ready = 1'b1;
        tick();
        bus.ucq_ready = 1'b0;
        @(negedge clk);
        chk("prio_empty", int'(bus.empty), 1);
        tick();

        // Round-robin among four always-requesting engines.
        set_eng(4'b1111, 10, 11, 12, 13);
        for (int i = 0; i < 5; i++) begin
            int g;
            g = i % 4;
            @(negedge clk);
            chk($sformatf("rr_grant%0d", i), int'(bus.eng_ready), 1 << g);
            $display("push eng%0d lit=%0d", g, 10 + g);
            sb.push_back(10 + g);
            tick();
        end
        set_eng(4'b0000, 0, 0, 0, 0);
        @(negedge clk);
        chk("rr_count", int'(bus.count), 5);
        tick();
        bus.ucq_ready = 1'b1;
        repeat (5) tick();
        bus.ucq_ready = 1'b0;
        @(negedge clk);
        chk("rr_drained", int'(bus.empty), 1);
        tick();

        // Full boundary: no push while full, even with a concurrent pop.
        for (int i = 0; i < 8; i++) begin
            set_eng(4'b0001, 30 + i, 0, 0, 0);
            @(negedge clk);
            chk($sformatf("fill%0d_ready", i), int'(bus.eng_ready), 1);
            $display("push eng0 lit=%0d", 30 + i);
            sb.push_back(30 + i);
            tick();
        end
        set_eng(4'b0001, 50, 0, 0, 0);
        bus.ucq_ready = 1'b1;
        @(negedge clk);
        chk("full_count", int'(bus.count), 8);
        chk("full_flag", int'(bus.full), 1);
        chk("full_no_grant", int'(bus.eng_ready), 0);
        tick();
        bus.ucq_ready = 1'b0;
        @(negedge clk);
        chk("full_after_pop_count", int'(bus.count), 7);
        chk("full_after_pop_flag", int'(bus.full), 0);
        chk("full_retry_grant", int'(bus.eng_ready), 1);
        $display("push eng0 lit=50");
        sb.push_back(50);
        tick();
        set_eng(4'b0000, 0, 0, 0, 0);
        @(negedge clk);
        chk("refull_count", int'(bus.count), 8);
        tick();
        bus.ucq_ready = 1'b1;
        repeat (8) tick();
        bus.ucq_ready = 1'b0;
        @(negedge clk);
        chk("full_drained", int'(bus.empty), 1);
        tick();

        // Flush: rr_ptr is 1 here; one engine grant moves it to 2.
        for (int i = 0; i < 4; i++) begin
            bus.mem_valid = 1'b1; bus.mem_lit = 10'(60 + i);
            @(negedge clk);
            chk($sformatf("flush_fill%0d", i), int'(bus.mem_ready), 1);
            $display("push mem lit=%0d", 60 + i);
            sb.push_back(60 + i);
            tick();
        end
        bus.mem_valid = 1'b0;
        set_eng(4'b1111, 70, 71, 72, 73);
        @(negedge clk);
        chk("flush_pre_grant", int'(bus.eng_ready), 2);
        $display("push eng1 lit=71");
        sb.push_back(71);
        tick();
        bus.flush = 1'b1; bus.mem_valid = 1'b1; bus.mem_lit = 10'd99;
        bus.ucq_ready = 1'b1;
        @(negedge clk);
        chk("flush_count_before", int'(bus.count), 5);
        chk("flush_mem_ready", int'(bus.mem_ready), 0);
        chk("flush_eng_ready", int'(bus.eng_ready), 0);
        $display("flush");
        sb.delete();
        tick();
        bus.flush = 1'b0; bus.mem_valid = 1'b0; bus.ucq_ready = 1'b0;
        @(negedge clk);
        chk("flush_count_after", int'(bus.count), 0);
        chk("flush_empty", int'(bus.empty), 1);
        chk("flush_ucq_valid", int'(bus.ucq_valid), 0);
        chk("flush_rr_kept", int'(bus.eng_ready), 4);
        $display("push eng2 lit=72");
        sb.push_back(72);
        tick();
        set_eng(4'b0000, 0, 0, 0, 0);
        bus.ucq_ready = 1'b1;
        tick();
        bus.ucq_ready = 1'b0;

        // Wrap-around stream: 20 literals, consumer starts two cycles late.
        max_cnt = 0;
        for (int k = 0; k < 22; k++) begin
            bus.mem_valid = (k < 20);
            bus.mem_lit   = 10'(100 + k);
            bus.ucq_ready = (k >= 2);
            @(negedge clk);
            if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
            if (k < 20) begin
                chk($sformatf("wrap_ready%0d", k), int'(bus.mem_ready), 1);
                $display("push mem lit=%0d", 100 + k);
                sb.push_back(100 + k);
            end
            tick();
        end
        bus.mem_valid = 1'b0; bus.ucq_ready = 1'b0;
        @(negedge clk);
        chk("wrap_max_le3", int'(max_cnt <= 3), 1);
        chk("wrap_empty", int'(bus.empty), 1);
        chk("wrap_sb_empty", sb.size(), 0);
        tick();

        // Asynchronous reset mid-operation drops content and rr_ptr (now 3).
        for (int i = 0; i < 2; i++) begin
            bus.mem_valid = 1'b1; bus.mem_lit = 10'(200 + i);
            @(negedge clk);
            sb.push_back(200 + i);
            tick();
        end
        bus.mem_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_count", int'(bus.count), 0);
        chk("midrst_ucq_valid", int'(bus.ucq_valid), 0);
        $display("reset");
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        tick();
        set_eng(4'b1111, 80, 81, 82, 83);
        @(negedge clk);
        chk("midrst_rr_zero", int'(bus.eng_ready), 1);
        sb.push_back(80);
        tick();
        set_eng(4'b0000, 0, 0, 0, 0);
        bus.ucq_ready = 1'b1;
        tick();
        bus.ucq_ready = 1'b0;
        @(negedge clk);
        chk("final_sb_drained", sb.size(), 0);
        chk("final_empty", int'(bus.empty), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uc_dispatch_arbiter.md
Name: uc_dispatch_arbiter

Overview:
- Shares one unit-clause queue (UCQ) between the clause-memory loader and NUM_ENG propagation engines.
- Each cycle it accepts at most one unit literal through a valid/ready handshake and buffers it in an internal FIFO of depth UCA_DEPTH.
- It presents the FIFO head to the UCQ consumer.
- A flush input, asserted on conflict, discards all buffered literals.

Parameters:
- UC_LENGTH, 1024: literal id space; LIT_W = $clog2(UC_LENGTH) = 10.
- NUM_ENG, 4: number of engine requesters; must be ≥1.
- UCA_DEPTH, 8: FIFO entries; power of two, ≥2; CNT_W = $clog2(UCA_DEPTH+1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- mem_valid  in  1  memory loader offers a literal
- mem_lit  in  LIT_W  memory literal
- mem_ready  out  1  memory literal accepted this cycle
- eng_valid  in  NUM_ENG  per-engine offer
- eng_lit  in  NUM_ENG*LIT_W  engine i literal in bits [i*LIT_W +: LIT_W]
- eng_ready  out  NUM_ENG  one-hot (or zero) accept
- flush  in  1  discard all queued literals
- ucq_valid  out  1  FIFO non-empty
- ucq_lit  out  LIT_W  FIFO head
- ucq_ready  in  1  consumer pops head
- count  out  CNT_W  current occupancy
- full  out  1  count == UCA_DEPTH
- empty  out  1  count == 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high; all state is cleared on posedge rst, independent of clk.
- Reset values: FIFO pointers 0; count 0; rr_ptr 0; ucq_valid 0; ucq_lit 0; empty 1; full 0; mem_ready 0; eng_ready 0.
- Reset mid-operation: all buffered literals are lost. No handshake completes in the reset cycle.
- Grant is combinational from current-cycle valids and registered state. At most one of {mem_ready, eng_ready[*]} is high.
- Grant is allowed only when !full && !flush. A full FIFO accepts no push, even if a pop occurs in the same cycle (no fall-through).
- Priority: memory is strict-first. If mem_valid, grant memory; engines wait.
- Engine arbitration is round-robin. Search starts at rr_ptr and wraps modulo NUM_ENG. The first engine with eng_valid set is granted.
- rr_ptr update: on an engine grant to engine g, rr_ptr <= (g+1) mod NUM_ENG. rr_ptr is unchanged on a memory grant, on no grant, or on flush.
- Push: the granted literal is written at the tail on the clock edge. It is visible on ucq_lit no earlier than the next cycle, so minimum latency is 1 cycle.
- Pop: occurs when ucq_valid && ucq_ready && !flush. Head advances; ucq_lit is the FIFO head, driven from storage with no extra register stage.
- Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
- Empty: ucq_valid = 0. ucq_ready is ignored and no underflow can occur.
- Pointers are LOG2(UCA_DEPTH) bits and wrap naturally. count is tracked separately and saturates by construction.
- Flush: in the flush cycle, all readies are 0 and no pop occurs. On the next edge, head = tail = 0 and count = 0. ucq_valid is 0 from the following cycle.
- Literal values pass through unmodified, with no dedup and no range checks.

Decomposition:
- Package uc_pkg holds: UC_LENGTH, UCA_DEPTH, NUM_ENG defaults; LIT_W; typedef lit_t (logic [LIT_W-1:0]); typedef uca_cnt_t.
- Sub-module uc_fifo: a parameterized sync FIFO with push/pop/flush, count, full and empty.
- The arbiter top holds the priority and round-robin logic and instantiates uc_fifo.

Test Plan:
- Reset then idle: rst pulse mid-cycle, all valids 0 → empty=1, count=0, ucq_valid=0, all readies 0, asynchronously during rst.
- Memory priority: mem_valid=1 lit 5, eng_valid=4'b1111 → mem_ready=1, eng_ready=0. Next cycle ucq_valid=1, ucq_lit=5.
- Round-robin: eng_valid=4'b1111 held, lits 10/11/12/13, ucq_ready=0 → grants e0,e1,e2,e3,e0 on consecutive cycles. Pops return 10,11,12,13,10.
- Full boundary: fill 8 entries (count=8, full=1) with ucq_ready=1 and eng_valid=1 in the same cycle → no push, one pop, count=7. Push is accepted the next cycle.
- Flush: count=5, flush=1 with mem_valid=1 → mem_ready=0. Next cycle count=0, empty=1, rr_ptr unchanged (next grant goes to the same engine as before the flush).
- Wrap-around: push 20 literals, each popped 2 cycles later → the output sequence equals the input sequence and count never exceeds 3.
